// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for single-cycle RAM port A: CPU (m0) has default priority,
// DMA (m1) is forced through after STARVE_LIMIT consecutive denied request cycles.
module ram_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [29:0] ram_address,
    output logic [31:0] ram_data,
    output logic [3:0]  ram_byteena,
    output logic        ram_wren,
    input  logic [31:0] ram_q
);

    // Handshake: a master holds req and its fields stable until it sees gnt in the
    // same cycle; a beat transfers on req & gnt. Read data is presented the next
    // cycle with rvalid (no back-pressure); a write needs no acknowledgement.

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;
    logic       rd_pend;
    logic       rd_owner;
    logic       m0_win;
    logic       m1_win;

    always_comb begin
        m1_win = ~reset & m1_req & (~m0_req | (starve_cnt == LIMIT));
        m0_win = ~reset & m0_req & ~m1_win;
    end

    assign m0_gnt = m0_win;
    assign m1_gnt = m1_win;

    always_comb begin
        ram_address = '0;
        ram_data    = '0;
        ram_byteena = 4'b1111;
        ram_wren    = 1'b0;
        if (m1_win) begin
            ram_address = m1_addr[31:2];
            ram_data    = m1_wdata;
            ram_byteena = m1_we ? m1_byteen : 4'b1111;
            ram_wren    = m1_we;
        end else if (m0_win) begin
            ram_address = m0_addr[31:2];
            ram_data    = m0_wdata;
            ram_byteena = m0_we ? m0_byteen : 4'b1111;
            ram_wren    = m0_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pend  <= (m0_win & ~m0_we) | (m1_win & ~m1_we);
            rd_owner <= m1_win;
            if (m1_req & ~m1_win) begin
                if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 8'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Gating with reset hides a read launched just before reset was raised.
    assign m0_rvalid = ~reset & rd_pend & ~rd_owner;
    assign m1_rvalid = ~reset & rd_pend & rd_owner;
    assign m0_rdata  = ram_q;
    assign m1_rdata  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM on port A and a
// scoreboard queue of {owner, rdata} checked whenever either rvalid is seen.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [29:0] ram_address;
    logic [31:0] ram_data;
    logic [3:0]  ram_byteena;
    logic        ram_wren;
    logic [31:0] ram_q;

    logic [32:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    logic [31:0] mem [logic [29:0]];

    ram_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_byteen(m0_byteen), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_byteen(m1_byteen), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_byteena(ram_byteena),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    // Clock and behavioural single-cycle RAM
    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic [31:0] w;
        w = mem.exists(ram_address) ? mem[ram_address] : 32'h0;
        ram_q <= w;
        if (ram_wren) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteena[b]) w[b*8 +: 8] = ram_data[b*8 +: 8];
            mem[ram_address] = w;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_byteen = be;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_byteen = be;
    endtask

    task automatic step(input string name, input logic g0, input logic g1,
                        input logic wren, input logic [3:0] be, input logic [29:0] addr,
                        input logic [31:0] data, input bit push, input logic [31:0] rd);
        @(negedge clk);
        chk({name, ".m0_gnt"}, 32'(m0_gnt), 32'(g0));
        chk({name, ".m1_gnt"}, 32'(m1_gnt), 32'(g1));
        chk({name, ".ram_wren"}, 32'(ram_wren), 32'(wren));
        chk({name, ".ram_byteena"}, 32'(ram_byteena), 32'(be));
        chk({name, ".ram_address"}, 32'(ram_address), 32'(addr));
        chk({name, ".ram_data"}, ram_data, data);
        if (push) exp_q.push_back({g1, rd});
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever read data is presented
    always @(negedge clk) begin
        logic [32:0] e;
        if (m0_rvalid && m1_rvalid) begin
            checks++; errors++;
            $display("FAIL rvalid_onehot: both rvalid high, required at most one");
        end else if (m0_rvalid || m1_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected: m0_rvalid=%0b m1_rvalid=%0b, required none",
                         m0_rvalid, m1_rvalid);
            end else begin
                e = exp_q.pop_front();
                if ({m1_rvalid, m0_rdata} !== e || m1_rdata !== m0_rdata) begin
                    errors++;
                    $display("FAIL rdata: owner=%0b data=%08h/%08h, required owner=%0b data=%08h",
                             m1_rvalid, m0_rdata, m1_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        mem[30'h4] = 32'hDEADBEEF;
        mem[30'h1] = 32'h00000011;
        mem[30'h2] = 32'h00000022;
        mem[30'h3] = 32'h00000033;
        reset = 1'b1;
        set_m0(1, 1, 32'h100, 32'h55, 4'hF);
        set_m1(1, 1, 32'h200, 32'h66, 4'hF);
        @(posedge clk);
        #1;
        // Requests are ignored while reset is high
        step("rst0", 0, 0, 0, 4'hF, 30'h0, 32'h0, 0, 0);
        step("rst1", 0, 0, 0, 4'hF, 30'h0, 32'h0, 0, 0);
        reset = 1'b0;
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        step("idle", 0, 0, 0, 4'hF, 30'h0, 32'h0, 0, 0);

        // m0 read of word 4
        set_m0(1, 0, 32'h10, 0, 4'h0);
        step("m0_rd", 1, 0, 0, 4'hF, 30'h4, 32'h0, 1, 32'hDEADBEEF);
        set_m0(0, 0, 0, 0, 0);

        // m1 byte write, then read back the same word
        set_m1(1, 1, 32'h0001_0004, 32'h0000_00A0, 4'b0001);
        step("m1_wr", 0, 1, 1, 4'b0001, 30'h4001, 32'hA0, 0, 0);
        set_m1(1, 0, 32'h0001_0004, 0, 4'h0);
        step("m1_rd", 0, 1, 0, 4'hF, 30'h4001, 32'h0, 1, 32'h0000_00A0);
        set_m1(0, 0, 0, 0, 0);
        step("idle2", 0, 0, 0, 4'hF, 30'h0, 32'h0, 0, 0);

        // Continuous contention: m1 forced through every fifth cycle
        set_m0(1, 1, 32'h100, 32'h1234_5678, 4'b1100);
        set_m1(1, 1, 32'h200, 32'h9ABC_DEF0, 4'b0011);
        for (int i = 1; i <= 12; i++) begin
            if (i % 5 == 0)
                step($sformatf("starve%0d", i), 0, 1, 1, 4'b0011, 30'h80, 32'h9ABC_DEF0, 0, 0);
            else
                step($sformatf("starve%0d", i), 1, 0, 1, 4'b1100, 30'h40, 32'h1234_5678, 0, 0);
        end
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        step("idle3", 0, 0, 0, 4'hF, 30'h0, 32'h0, 0, 0);

        // Alternating back-to-back reads
        set_m0(1, 0, 32'h4, 0, 0);
        step("alt0", 1, 0, 0, 4'hF, 30'h1, 32'h0, 1, 32'h11);
        set_m0(0, 0, 0, 0, 0);
        set_m1(1, 0, 32'h8, 0, 0);
        step("alt1", 0, 1, 0, 4'hF, 30'h2, 32'h0, 1, 32'h22);
        set_m1(0, 0, 0, 0, 0);
        set_m0(1, 0, 32'hC, 0, 0);
        step("alt2", 1, 0, 0, 4'hF, 30'h3, 32'h0, 1, 32'h33);
        set_m0(0, 0, 0, 0, 0);
        step("idle4", 0, 0, 0, 4'hF, 30'h0, 32'h0, 0, 0);
        step("idle5", 0, 0, 0, 4'hF, 30'h0, 32'h0, 0, 0);

        // Read in flight across reset; counter built up beforehand must clear
        set_m0(1, 1, 32'h100, 32'h1, 4'hF);
        set_m1(1, 1, 32'h200, 32'h2, 4'hF);
        step("pre0", 1, 0, 1, 4'hF, 30'h40, 32'h1, 0, 0);
        step("pre1", 1, 0, 1, 4'hF, 30'h40, 32'h1, 0, 0);
        set_m0(1, 0, 32'h10, 0, 0);
        step("rd_kill", 1, 0, 0, 4'hF, 30'h4, 32'h0, 0, 0);
        reset = 1'b1;
        set_m0(1, 1, 32'h100, 32'h1, 4'hF);
        step("mid_rst", 0, 0, 0, 4'hF, 30'h0, 32'h0, 0, 0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++)
            step($sformatf("post_rst%0d", i), 1, 0, 1, 4'hF, 30'h40, 32'h1, 0, 0);
        step("post_rst5", 0, 1, 1, 4'hF, 30'h80, 32'h2, 0, 0);

        // Dropped m1 request restarts the counter
        for (int i = 1; i <= 3; i++)
            step($sformatf("drop_pre%0d", i), 1, 0, 1, 4'hF, 30'h40, 32'h1, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        step("drop", 1, 0, 1, 4'hF, 30'h40, 32'h1, 0, 0);
        set_m1(1, 1, 32'h200, 32'h2, 4'hF);
        for (int i = 1; i <= 4; i++)
            step($sformatf("drop_post%0d", i), 1, 0, 1, 4'hF, 30'h40, 32'h1, 0, 0);
        step("drop_post5", 0, 1, 1, 4'hF, 30'h80, 32'h2, 0, 0);
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        step("idle6", 0, 0, 0, 4'hF, 30'h0, 32'h0, 0, 0);
        step("idle7", 0, 0, 0, 4'hF, 30'h0, 32'h0, 0, 0);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
